// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices, multicast header fields,
// the output mask type and a modulo-5 port increment.
package noc_pkg;

    localparam int NPORTS = 5;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    localparam int MCAST_FLAG_BIT = 31;
    localparam int MCAST_MASK_LSB = 26;

    typedef logic [4:0] mask_t;
    typedef logic [2:0] port_t;

    function automatic port_t port_add(port_t base, int k);
        logic [3:0] s;
        s = {1'b0, base} + 4'(k);
        if (s >= 4'(NPORTS)) begin
            s = s - 4'(NPORTS);
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/mcast_starve_guard.sv
// Per-input wait counters and the IDLE/RESERVE reservation FSM that
// hands a starving wide multicast exclusive claim on its outputs.
module mcast_starve_guard
    import noc_pkg::*;
#(
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  port_t       rr,
    input  mask_t       req_valid,
    input  logic [24:0] req_mask,
    input  mask_t       grant,
    output logic        active,
    output port_t       owner,
    output mask_t       res_mask
);

    typedef enum logic {
        IDLE,
        RESERVE
    } state_t;

    localparam logic [CNT_W-1:0] W_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] W_LIM = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] w [NPORTS];
    logic             hit;
    port_t            hit_idx;
    port_t            idx;

    // Candidate owner: first starved input in rr order still waiting.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = port_add(rr, k);
            if (!hit && w[idx] >= W_LIM && req_valid[idx] && !grant[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign res_mask = active ? req_mask[int'(owner)*5 +: 5] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            active <= 1'b0;
            owner  <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                w[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (grant[i] || !req_valid[i]) begin
                    w[i] <= '0;
                end else if (req_mask[i*5 +: 5] != '0 && w[i] != W_MAX) begin
                    w[i] <= w[i] + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        state  <= RESERVE;
                        active <= 1'b1;
                        owner  <= hit_idx;
                    end
                end
                RESERVE: begin
                    if (grant[owner] || !req_valid[owner]) begin
                        state  <= IDLE;
                        active <= 1'b0;
                        owner  <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                    owner  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mcast_switch_allocator.sv
// Atomic multicast switch allocator with round-robin input priority.
// Define MCAST_STARVE_GUARD_EN to build the starvation reservation guard.
module mcast_switch_allocator
    import noc_pkg::*;
#(
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  req_valid,
    input  logic [24:0] req_mask,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel,
    output logic        starve_active,
    output logic [2:0]  starve_port
);

    if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_cfg
        $error("STARVE_LIMIT must be below 2**CNT_W");
    end

    port_t       rr;
    logic        g_active;
    port_t       g_owner;
    mask_t       g_res;
    mask_t       claimed;
    mask_t       grant_c;
    mask_t       valid_c;
    logic [14:0] sel_c;
    logic        rr_hit;
    port_t       rr_first;
    mask_t       m;
    port_t       idx;

`ifdef MCAST_STARVE_GUARD_EN
    mcast_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_guard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr        (rr),
        .req_valid (req_valid),
        .req_mask  (req_mask),
        .grant     (grant_c),
        .active    (g_active),
        .owner     (g_owner),
        .res_mask  (g_res)
    );
`else
    assign g_active = 1'b0;
    assign g_owner  = '0;
    assign g_res    = '0;
`endif

    always_comb begin
        claimed  = ~out_ready;
        grant_c  = '0;
        valid_c  = '0;
        sel_c    = '0;
        rr_hit   = 1'b0;
        rr_first = '0;
        m        = '0;
        idx      = '0;
        if (g_active) begin
            m = req_mask[int'(g_owner)*5 +: 5];
            if (req_valid[g_owner] && m != '0 && (m & claimed) == '0) begin
                grant_c[g_owner] = 1'b1;
                valid_c          = valid_c | m;
                for (int j = 0; j < NPORTS; j++) begin
                    if (m[j]) begin
                        sel_c[j*3 +: 3] = g_owner;
                    end
                end
            end
            // Owner's outputs stay fenced off whether or not it won.
            claimed = claimed | g_res;
        end
        for (int k = 0; k < NPORTS; k++) begin
            idx = port_add(rr, k);
            m   = req_mask[int'(idx)*5 +: 5];
            if (!(g_active && idx == g_owner) && req_valid[idx] &&
                m != '0 && (m & claimed) == '0) begin
                grant_c[idx] = 1'b1;
                claimed      = claimed | m;
                valid_c      = valid_c | m;
                for (int j = 0; j < NPORTS; j++) begin
                    if (m[j]) begin
                        sel_c[j*3 +: 3] = idx;
                    end
                end
                if (!rr_hit) begin
                    rr_hit   = 1'b1;
                    rr_first = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= '0;
        end else if (rr_hit) begin
            rr <= port_add(rr_first, 1);
        end
    end

    assign grant         = rst_n ? grant_c : '0;
    assign out_valid     = rst_n ? valid_c : '0;
    assign out_sel       = rst_n ? sel_c : '0;
    assign starve_active = rst_n & g_active;
    assign starve_port   = rst_n ? g_owner : '0;

endmodule

// File: tb/tb_mcast_switch_allocator.sv
// Directed bench: vector table for single-cycle allocation plus
// sequences for round-robin, starvation and reset-mid-reservation.
module tb_mcast_switch_allocator;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [24:0] req_mask;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic        starve_active;
    logic [2:0]  starve_port;

    int checks = 0;
    int errors = 0;

    mcast_switch_allocator #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_mask      (req_mask),
        .out_ready     (out_ready),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_sel       (out_sel),
        .starve_active (starve_active),
        .starve_port   (starve_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  valid;
        logic [24:0] mask;
        logic [4:0]  ready;
        logic [4:0]  exp_grant;
        logic [4:0]  exp_ov;
        logic [14:0] exp_sel;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_mask  = '0;
        out_ready = 5'b11111;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Input 0 asks for all outputs; inputs 1/2 alternately take out 0/1
    // while the other of those two outputs is still busy downstream.
    task automatic ramp(input int t, input logic in0);
        req_mask = {5'b0, 5'b0, 5'b00010, 5'b00001, 5'b11111};
        if (t % 2 == 1) begin
            req_valid = {2'b00, 1'b1, 1'b0, in0};
            out_ready = 5'b11110;
        end else begin
            req_valid = {2'b00, 1'b0, 1'b1, in0};
            out_ready = 5'b11101;
        end
    endtask

    initial begin
        int t;
        int k;
        logic g;

        vecs[0]  = '{5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00010}, 5'b11111,
                     5'b00001, 5'b00010, 15'h0000};
        vecs[1]  = '{5'b10000, {5'b01001, 5'b0, 5'b0, 5'b0, 5'b0}, 5'b10111,
                     5'b00000, 5'b00000, 15'h0000};
        vecs[2]  = '{5'b10000, {5'b01001, 5'b0, 5'b0, 5'b0, 5'b0}, 5'b11111,
                     5'b10000, 5'b01001, 15'h0804};
        vecs[3]  = '{5'b01001, {5'b0, 5'b11100, 5'b0, 5'b0, 5'b00011}, 5'b11111,
                     5'b01001, 5'b11111, 15'h36C0};
        vecs[4]  = '{5'b00110, {5'b0, 5'b0, 5'b00110, 5'b00010, 5'b0}, 5'b11111,
                     5'b00010, 5'b00010, 15'h0008};
        vecs[5]  = '{5'b00110, {5'b0, 5'b0, 5'b00110, 5'b00010, 5'b0}, 5'b11111,
                     5'b00100, 5'b00110, 15'h0090};
        vecs[6]  = '{5'b00011, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b0}, 5'b11111,
                     5'b00010, 5'b00010, 15'h0008};
        vecs[7]  = '{5'b00000, {25{1'b1}}, 5'b11111,
                     5'b00000, 5'b00000, 15'h0000};
        vecs[8]  = '{5'b11111, {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001},
                     5'b11111, 5'b11111, 5'b11111, 15'h4688};
        vecs[9]  = '{5'b11111, {5{5'b01000}}, 5'b11111,
                     5'b01000, 5'b01000, 15'h0600};
        vecs[10] = '{5'b11111, {5{5'b01000}}, 5'b11111,
                     5'b10000, 5'b01000, 15'h0800};
        vecs[11] = '{5'b11111, {5{5'b01000}}, 5'b10111,
                     5'b00000, 5'b00000, 15'h0000};
        vecs[12] = '{5'b11111, {5{5'b01000}}, 5'b11111,
                     5'b00001, 5'b01000, 15'h0000};

        // Outputs forced low while reset is held, even with live requests.
        rst_n     = 1'b0;
        req_valid = 5'b11111;
        req_mask  = {25{1'b1}};
        out_ready = 5'b11111;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_starve_active", starve_active, 0);
        chk("rst_starve_port", starve_port, 0);
        do_reset();
        #2;
        chk("idle_grant", grant, 0);
        chk("idle_starve", starve_active, 0);
        tick();

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            req_mask  = vecs[i].mask;
            out_ready = vecs[i].ready;
            #2;
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_out_sel", i), out_sel, vecs[i].exp_sel);
            tick();
        end
        req_valid = '0;
        tick();

        do_reset();
        req_valid = 5'b00110;
        req_mask  = {5'b0, 5'b0, 5'b10000, 5'b10000, 5'b0};
        out_ready = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("rr%0d_grant", i), grant,
                (i % 2 == 1) ? 5'b00100 : 5'b00010);
            chk($sformatf("rr%0d_sel4", i), out_sel[14:12],
                (i % 2 == 1) ? 3'd2 : 3'd1);
            tick();
        end

        do_reset();
        t = 0;
`ifdef MCAST_STARVE_GUARD_EN
        while (!starve_active && t < 8) begin
            ramp(t, 1'b1);
            #2;
            chk("starve_wait_in0", grant[0], 0);
            tick();
            t++;
        end
        chk("starve_seen", starve_active, 1);
        chk("starve_port", starve_port, 0);
        chk("starve_latency_ok", t <= 6, 1);
        g = 1'b0;
        k = 0;
        while (!g && k < 3) begin
            ramp(t, 1'b1);
            out_ready = 5'b11111;
            #2;
            if (grant[0]) begin
                g = 1'b1;
                chk("owner_only_grant", grant, 5'b00001);
                chk("owner_out_valid", out_valid, 5'b11111);
                chk("owner_out_sel", out_sel, 0);
            end
            tick();
            t++;
            k++;
        end
        chk("owner_granted", g, 1);
        chk("owner_latency_ok", k <= 2, 1);
        ramp(t, 1'b0);
        #2;
        chk("starve_released", starve_active, 0);
        tick();
        t++;
        k = 0;
        while (!starve_active && k < 8) begin
            ramp(t, 1'b1);
            tick();
            t++;
            k++;
        end
        chk("reserve_again", starve_active, 1);
`else
        for (int i = 0; i < 50; i++) begin
            ramp(i, 1'b1);
            #2;
            chk($sformatf("nostarve%0d_in0", i), grant[0], 0);
            tick();
        end
        chk("guard_off_active", starve_active, 0);
        chk("guard_off_port", starve_port, 0);
`endif
        ramp(t, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_grant", grant, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sel", out_sel, 0);
        chk("midrst_starve_active", starve_active, 0);
        chk("midrst_starve_port", starve_port, 0);
        tick();
        rst_n     = 1'b1;
        req_valid = 5'b10001;
        req_mask  = {5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001};
        out_ready = 5'b11111;
        #2;
        chk("postrst_starve", starve_active, 0);
        chk("postrst_rr_grant", grant, 5'b00001);
        chk("postrst_rr_sel0", out_sel[2:0], 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcast_switch_allocator.md
# mcast_switch_allocator

Per-router switch allocator for the multicast-enabled mesh router. It takes the head-of-FIFO requests of the five input ports, each a 5-bit output mask, and grants inputs whose requested outputs are all free and ready in the same cycle. Replication is atomic: an input gets every requested output or none. Round-robin priority rotates between inputs, and an optional starvation guard reserves outputs for wide multicasts that keep losing. It sits between the router's input FIFOs and its output crossbar, and drives crossbar selects and FIFO pops.

## Interface
- `STARVE_LIMIT`, default 15: wait cycles before an input is declared starved.
- `CNT_W`, default 4: width of the per-input wait counter; must satisfy STARVE_LIMIT < 2^CNT_W.
- `clk`  in  1  router clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  5  input i has a head flit.
- `req_mask`  in  25  output mask of input i at `[i*5 +: 5]`; bit j selects output j. Port order is 0=N, 1=E, 2=S, 3=W, 4=L.
- `out_ready`  in  5  output j can accept a flit this cycle.
- `grant`  out  5  input i is granted; its flit is popped this cycle.
- `out_valid`  out  5  output j is driven this cycle.
- `out_sel`  out  15  source input for output j at `[j*3 +: 3]`; value is 0 when out_valid[j]=0.
- `starve_active`  out  1  a reservation is in force.
- `starve_port`  out  3  input that owns the reservation; 0 when idle.

## Operation
- **Claimed set.** C starts as `~out_ready`.
  - With the guard active, C also includes the owner's mask, but only when other inputs are evaluated.
- **Search.**
  - Order is owner first (when a reservation is active), then inputs rr, rr+1, … modulo 5, skipping the owner.
  - Input i is granted iff req_valid[i]=1, mask_i≠0, and (mask_i & C)=0. On a grant, C |= mask_i.
- **Illegal request.** req_valid with a zero mask is ignored: no grant and no counter increment.
- **Output mapping.** For each output j in a granted mask: out_valid[j]=1 and out_sel[j]=i. U-turns, where mask bit i is set for input i, are allowed.
- **Round-robin pointer.**
  - If any non-owner grant occurs, rr <= (first non-owner granted index) + 1 mod 5.
  - Otherwise rr is unchanged.
- **Input obligation.** An input holds req_valid and its mask stable until granted.
- **Starvation FSM** (`MCAST_STARVE_GUARD_EN` only): states IDLE and RESERVE.
  - Per-input counter w_i:
    - cleared on grant or when req_valid[i]=0;
    - otherwise incremented by 1, saturating at 2^CNT_W-1.
  - IDLE→RESERVE when some w_i ≥ STARVE_LIMIT. The owner is the first such i in rr order.
  - RESERVE→IDLE when the owner is granted or drops req_valid.
  - No other transitions. Only one reservation exists at a time.

## Timing
- Grant, out_valid and out_sel are combinational from the current request, out_ready and registered state. The pop occurs at the same clock edge as the grant.
- rr, counters and FSM update on the rising clk edge.
- A reservation takes effect in the cycle after the counter crosses STARVE_LIMIT.
- Reset: every output is 0 while rst_n=0.
  - rr, w_i and FSM state (IDLE) are cleared at the edge where rst_n is sampled low.
  - Mid-RESERVE reset drops the reservation without a grant.
- The same cycle can see a reservation exit and a grant to another input. The owner's outputs become available to other inputs only in the next cycle.
- When out_ready drops, any request that touches that output gets no grant. Partial issue never happens.

## Configuration
- `MCAST_STARVE_GUARD_EN` defined: counters and the IDLE/RESERVE FSM are built as described above.
- `MCAST_STARVE_GUARD_EN` undefined:
  - no counters and no FSM;
  - starve_active=0 and starve_port=0;
  - allocation is pure round-robin, and a wide mask may starve indefinitely.

## Structure
- `noc_pkg` holds:
  - NPORTS=5 and the port index constants N/E/S/W/L;
  - MCAST_FLAG_BIT=31 and MCAST_MASK_LSB=26;
  - the mask typedef `[4:0]`.
- One sub-module, `mcast_starve_guard`: the counters, the FSM, and owner/reserved-mask outputs. It is instantiated under the macro.

## Test plan
- **Single unicast.** Input 0, mask 00010, all outputs ready → grant=00001, out_valid=00010, out_sel[5:3]=0.
- **Atomic multicast.** Input 4, mask 01001, out_ready=10111 → grant=0, out_valid=0. Raise out_ready[3] → grant=10000 and out_valid=01001 in one cycle.
- **Parallel disjoint.** Input 0 mask 00011, input 3 mask 11100 → grant=01001, out_sel[5:3]=0, out_sel[14:12]=3.
- **Round-robin fairness.** Inputs 1 and 2 both continuously request mask 10000 after reset → grants alternate 1, 2, 1, 2 for 8 cycles.
- **Starvation, STARVE_LIMIT=4, guard defined.**
  - Stimulus: input 0 requests mask 11111 while inputs 1 and 2 alternately take outputs 0 and 1.
  - Required response: starve_active=1 with starve_port=0 within 6 cycles, then input 0 granted within 2 further cycles, then starve_active returns to 0.
  - Without the macro, the same stimulus gives no grant to input 0 for 50 cycles.
- **Reset mid-RESERVE.** Pulse rst_n low for one cycle → all outputs 0 during that cycle, starve_active=0 afterwards, and rr restarts at input 0.
